// File: rtl/xctcmsg_pkg.sv
// Shared types for the xctcmsg messaging unit: message payloads, send requests,
// completion records and commit-safety queries.
package xctcmsg_pkg;

  localparam int NODE_ID_W = 4;
  localparam int REG_W     = 5;
  localparam int GL_W      = 8;

  typedef logic [NODE_ID_W-1:0] node_id_t;
  typedef logic [31:0]          message_t;
  typedef logic [REG_W-1:0]     reg_idx_t;

  typedef struct packed {
    logic [GL_W-1:0] gl_index;
  } passthrough_t;

  typedef struct packed {
    message_t     message;
    node_id_t     destination;
    reg_idx_t     rd;
    passthrough_t passthrough;
  } send_queue_data_t;

  typedef struct packed {
    node_id_t destination;
    message_t message;
  } outgoing_entry_t;

  typedef struct packed {
    node_id_t destination;
    message_t message;
  } interface_transmit_data_t;

  typedef struct packed {
    message_t message;
  } interface_receive_data_t;

  typedef struct packed {
    logic [31:0]  value;
    reg_idx_t     rd;
    passthrough_t passthrough;
  } writeback_arbiter_data_t;

  typedef struct packed {
    logic [GL_W-1:0] gl_index;
  } commit_safety_request_t;

endpackage

// File: rtl/mbox_transmit_if.sv
// Handshake bundle around the transmit unit: send queue in, writeback completion,
// network interface and loopback outputs. master = transmit side.
interface mbox_transmit_if;
  import xctcmsg_pkg::*;

  logic                     send_queue_transmit_valid;
  logic                     transmit_send_queue_ready;
  send_queue_data_t         send_queue_transmit_data;

  logic                     transmit_writeback_arbiter_valid;
  logic                     writeback_arbiter_transmit_acknowledge;
  writeback_arbiter_data_t  transmit_writeback_arbiter_data;

  logic                     transmit_interface_valid;
  logic                     interface_transmit_ready;
  interface_transmit_data_t transmit_interface_data;

  logic                     transmit_loopback_valid;
  logic                     loopback_transmit_ready;
  interface_receive_data_t  transmit_loopback_data;

  modport master (
    input  send_queue_transmit_valid, send_queue_transmit_data,
           writeback_arbiter_transmit_acknowledge,
           interface_transmit_ready, loopback_transmit_ready,
    output transmit_send_queue_ready,
           transmit_writeback_arbiter_valid, transmit_writeback_arbiter_data,
           transmit_interface_valid, transmit_interface_data,
           transmit_loopback_valid, transmit_loopback_data
  );

  modport slave (
    output send_queue_transmit_valid, send_queue_transmit_data,
           writeback_arbiter_transmit_acknowledge,
           interface_transmit_ready, loopback_transmit_ready,
    input  transmit_send_queue_ready,
           transmit_writeback_arbiter_valid, transmit_writeback_arbiter_data,
           transmit_interface_valid, transmit_interface_data,
           transmit_loopback_valid, transmit_loopback_data
  );

endinterface

// File: rtl/mbox_transmit_msg_fifo.sv
// Generic SIZE-deep FIFO with registered head/tail pointers; SIZE need not be a
// power of two, so pointers wrap explicitly at SIZE-1.
module msg_fifo #(
  parameter type T    = logic,
  parameter int  SIZE = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic push,
  input  T     push_data,
  input  logic pop,
  output T     head,
  output logic full,
  output logic empty
);

  localparam int PTR_W = (SIZE > 1) ? $clog2(SIZE) : 1;
  localparam int CNT_W = $clog2(SIZE + 1);

  T                 mem [SIZE];
  logic [PTR_W-1:0] head_ptr;
  logic [PTR_W-1:0] tail_ptr;
  logic [CNT_W-1:0] count;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(SIZE - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full    = (count == CNT_W'(SIZE));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[head_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_ptr <= '0;
      tail_ptr <= '0;
      count    <= '0;
    end else begin
      if (do_push) tail_ptr <= next_ptr(tail_ptr);
      if (do_pop)  head_ptr <= next_ptr(head_ptr);
      if (do_push && !do_pop)      count <= count + 1'b1;
      else if (!do_push && do_pop) count <= count - 1'b1;
    end
  end

  // Storage needs no reset: nothing is visible while count is zero.
  always_ff @(posedge clk) begin
    if (do_push) mem[tail_ptr] <= push_data;
  end

endmodule

// File: rtl/mbox_transmit.sv
// Transmit side of xctcmsg: buffers committed sends, routes each to the network
// or to loopback by destination, and reports completion to the writeback arbiter.
import xctcmsg_pkg::*;

module mbox_transmit #(
  parameter int SIZE   = 4,
  parameter int NODE_W = NODE_ID_W
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   flush,
  input  logic [NODE_W-1:0]      local_node_id,
  mbox_transmit_if.master        bus,
  output commit_safety_request_t transmit_csu_request,
  input  logic                   csu_transmit_grant
);

  outgoing_entry_t         push_entry;
  outgoing_entry_t         head_entry;
  logic                    fifo_full;
  logic                    fifo_empty;
  logic                    push;
  logic                    pop;
  logic                    head_is_local;
  logic                    wb_valid;
  writeback_arbiter_data_t wb_data;

  // Accept only granted requests, with room in the FIFO and a free completion slot.
  assign bus.transmit_send_queue_ready = csu_transmit_grant && !flush && !fifo_full &&
                                         (!wb_valid || bus.writeback_arbiter_transmit_acknowledge);
  assign push = bus.send_queue_transmit_valid && bus.transmit_send_queue_ready;

  assign push_entry.destination = bus.send_queue_transmit_data.destination;
  assign push_entry.message     = bus.send_queue_transmit_data.message;

  msg_fifo #(
    .T    (outgoing_entry_t),
    .SIZE (SIZE)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data (push_entry),
    .pop       (pop),
    .head      (head_entry),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign head_is_local = (head_entry.destination == NODE_ID_W'(local_node_id));

  assign bus.transmit_interface_valid = !fifo_empty && !head_is_local;
  assign bus.transmit_loopback_valid  = !fifo_empty && head_is_local;
  assign bus.transmit_interface_data.destination = head_entry.destination;
  assign bus.transmit_interface_data.message     = head_entry.message;
  assign bus.transmit_loopback_data.message      = head_entry.message;

  assign pop = (bus.transmit_interface_valid && bus.interface_transmit_ready) ||
               (bus.transmit_loopback_valid  && bus.loopback_transmit_ready);

  // A new completion overrides a same-cycle acknowledge; flush drops a pending one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_valid <= 1'b0;
      wb_data  <= '0;
    end else if (push) begin
      wb_valid            <= 1'b1;
      wb_data.value       <= 32'd1;
      wb_data.rd          <= bus.send_queue_transmit_data.rd;
      wb_data.passthrough <= bus.send_queue_transmit_data.passthrough;
    end else if (flush || bus.writeback_arbiter_transmit_acknowledge) begin
      wb_valid <= 1'b0;
    end
  end

  assign bus.transmit_writeback_arbiter_valid = wb_valid;
  assign bus.transmit_writeback_arbiter_data  = wb_data;

`ifdef XCTCMSG_SARGANTANA
  assign transmit_csu_request.gl_index = bus.send_queue_transmit_data.passthrough.gl_index;
`else
  assign transmit_csu_request = '0;
`endif

endmodule

// File: tb/tb_mbox_transmit.sv
// Directed bench for mbox_transmit: a negedge monitor checks every transfer
// against queues of expected messages and completions filled as sends are accepted.
module tb_mbox_transmit;
  import xctcmsg_pkg::*;

  localparam int SIZE = 4;

  logic                   clk = 1'b0;
  logic                   rst_n = 1'b0;
  logic                   flush = 1'b0;
  logic                   grant = 1'b0;
  logic [3:0]             local_id = 4'd5;
  commit_safety_request_t csu_req;

  int errors = 0;
  int checks = 0;

  message_t                exp_if_q[$];
  node_id_t                exp_if_dest_q[$];
  message_t                exp_lb_q[$];
  writeback_arbiter_data_t exp_wb_q[$];

  mbox_transmit_if bus_if();

  mbox_transmit #(
    .SIZE   (SIZE),
    .NODE_W (4)
  ) dut (
    .clk                  (clk),
    .rst_n                (rst_n),
    .flush                (flush),
    .local_node_id        (local_id),
    .bus                  (bus_if),
    .transmit_csu_request (csu_req),
    .csu_transmit_grant   (grant)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic applyStimulus(input node_id_t dest, input message_t msg, input reg_idx_t rd, input logic [7:0] gl);
    bit accepted = 1'b0;
    bus_if.send_queue_transmit_valid = 1'b1;
    bus_if.send_queue_transmit_data  = '{message: msg, destination: dest, rd: rd, passthrough: '{gl_index: gl}};
    for (int i = 0; i < 20 && !accepted; i++) begin
      @(negedge clk);
      if (bus_if.transmit_send_queue_ready) accepted = 1'b1;
      else step();
    end
    if (!accepted) begin
      checks++;
      errors++;
      $display("[TB] FAIL accept_timeout: message 0x%0h never accepted, expected acceptance", msg);
    end
    step();
    bus_if.send_queue_transmit_valid = 1'b0;
  endtask

  task automatic ackWb();
    step();
    bus_if.writeback_arbiter_transmit_acknowledge = 1'b1;
    step();
    bus_if.writeback_arbiter_transmit_acknowledge = 1'b0;
  endtask

  task automatic waitEmpty(input string name);
    bit drained = 1'b0;
    for (int i = 0; i < 40 && !drained; i++) begin
      @(negedge clk);
      if (!bus_if.transmit_interface_valid && !bus_if.transmit_loopback_valid) drained = 1'b1;
    end
    checkOutput(name, {63'd0, drained}, 64'd1);
  endtask

  // Scoreboard monitor: consume expectations on each transfer, then record new sends.
  always @(negedge clk) begin
    if (rst_n) begin
      send_queue_data_t d;
      if (bus_if.transmit_interface_valid || bus_if.transmit_loopback_valid)
        checkOutput("one_port", {63'd0, bus_if.transmit_interface_valid & bus_if.transmit_loopback_valid}, 64'd0);
      if (bus_if.transmit_interface_valid && bus_if.interface_transmit_ready) begin
        if (exp_if_q.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL if_unexpected: got 0x%0h, expected no transfer", bus_if.transmit_interface_data.message);
        end else begin
          checkOutput("if_msg", 64'(bus_if.transmit_interface_data.message), 64'(exp_if_q.pop_front()));
          checkOutput("if_dest", 64'(bus_if.transmit_interface_data.destination), 64'(exp_if_dest_q.pop_front()));
        end
      end
      if (bus_if.transmit_loopback_valid && bus_if.loopback_transmit_ready) begin
        if (exp_lb_q.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL lb_unexpected: got 0x%0h, expected no transfer", bus_if.transmit_loopback_data.message);
        end else begin
          checkOutput("lb_msg", 64'(bus_if.transmit_loopback_data.message), 64'(exp_lb_q.pop_front()));
        end
      end
      if (bus_if.transmit_writeback_arbiter_valid && bus_if.writeback_arbiter_transmit_acknowledge) begin
        if (exp_wb_q.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL wb_unexpected: got 0x%0h, expected no completion", bus_if.transmit_writeback_arbiter_data);
        end else begin
          checkOutput("wb_data", 64'(bus_if.transmit_writeback_arbiter_data), 64'(exp_wb_q.pop_front()));
        end
      end
      if (flush) exp_wb_q.delete();
      if (bus_if.send_queue_transmit_valid && bus_if.transmit_send_queue_ready) begin
        d = bus_if.send_queue_transmit_data;
        if (d.destination == local_id) begin
          exp_lb_q.push_back(d.message);
        end else begin
          exp_if_q.push_back(d.message);
          exp_if_dest_q.push_back(d.destination);
        end
        exp_wb_q.push_back('{value: 32'd1, rd: d.rd, passthrough: d.passthrough});
      end
    end
  end

  initial begin
    bus_if.send_queue_transmit_valid              = 1'b0;
    bus_if.send_queue_transmit_data               = '0;
    bus_if.writeback_arbiter_transmit_acknowledge = 1'b0;
    bus_if.interface_transmit_ready               = 1'b0;
    bus_if.loopback_transmit_ready                = 1'b0;

    repeat (3) step();
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("rst_ready", {63'd0, bus_if.transmit_send_queue_ready}, 64'd0);
    checkOutput("rst_if_valid", {63'd0, bus_if.transmit_interface_valid}, 64'd0);
    checkOutput("rst_lb_valid", {63'd0, bus_if.transmit_loopback_valid}, 64'd0);
    checkOutput("rst_wb_valid", {63'd0, bus_if.transmit_writeback_arbiter_valid}, 64'd0);
    checkOutput("rst_csu", 64'(csu_req), 64'd0);

    // Remote send goes to the network interface the cycle after acceptance.
    step();
    grant = 1'b1;
    bus_if.interface_transmit_ready = 1'b1;
    bus_if.loopback_transmit_ready  = 1'b1;
    applyStimulus(4'd3, 32'hA5, 5'd1, 8'd2);
    @(negedge clk);
    checkOutput("t1_if_valid", {63'd0, bus_if.transmit_interface_valid}, 64'd1);
    checkOutput("t1_if_msg", 64'(bus_if.transmit_interface_data.message), 64'hA5);
    checkOutput("t1_wb_valid", {63'd0, bus_if.transmit_writeback_arbiter_valid}, 64'd1);
    checkOutput("t1_wb_value", 64'(bus_if.transmit_writeback_arbiter_data.value), 64'd1);
    ackWb();

    // Local destination goes to loopback only.
    applyStimulus(4'd5, 32'h5C, 5'd2, 8'd3);
    @(negedge clk);
    checkOutput("t2_lb_valid", {63'd0, bus_if.transmit_loopback_valid}, 64'd1);
    checkOutput("t2_if_valid", {63'd0, bus_if.transmit_interface_valid}, 64'd0);
    step();
    @(negedge clk);
    checkOutput("t2_empty", {62'd0, bus_if.transmit_loopback_valid, bus_if.transmit_interface_valid}, 64'd0);
    ackWb();

    // Fill to SIZE with the interface stalled; no pop-through when full.
    step();
    bus_if.interface_transmit_ready = 1'b0;
    bus_if.writeback_arbiter_transmit_acknowledge = 1'b1;
    for (int i = 0; i < SIZE; i++) applyStimulus(4'd1, 32'h10 + 32'(i), 5'(i), 8'(i));
    bus_if.send_queue_transmit_valid = 1'b1;
    bus_if.send_queue_transmit_data  = '{message: 32'h20, destination: 4'd1, rd: 5'd9, passthrough: '{gl_index: 8'h9}};
    @(negedge clk);
    checkOutput("t3_full_ready", {63'd0, bus_if.transmit_send_queue_ready}, 64'd0);
    step();
    bus_if.interface_transmit_ready = 1'b1;
    @(negedge clk);
    checkOutput("t3_no_pop_through", {63'd0, bus_if.transmit_send_queue_ready}, 64'd0);
    step();
    bus_if.interface_transmit_ready = 1'b0;
    @(negedge clk);
    checkOutput("t3_ready_after_pop", {63'd0, bus_if.transmit_send_queue_ready}, 64'd1);
    step();
    bus_if.send_queue_transmit_valid = 1'b0;
    bus_if.interface_transmit_ready  = 1'b1;
    waitEmpty("t3_drain");
    step();
    bus_if.writeback_arbiter_transmit_acknowledge = 1'b0;

    // A stalled remote head blocks a ready local entry behind it.
    step();
    bus_if.interface_transmit_ready = 1'b0;
    bus_if.writeback_arbiter_transmit_acknowledge = 1'b1;
    applyStimulus(4'd2, 32'h30, 5'd3, 8'h30);
    applyStimulus(4'd5, 32'h31, 5'd4, 8'h31);
    bus_if.writeback_arbiter_transmit_acknowledge = 1'b0;
    @(negedge clk);
    checkOutput("t4_lb_blocked1", {63'd0, bus_if.transmit_loopback_valid}, 64'd0);
    checkOutput("t4_if_head", {63'd0, bus_if.transmit_interface_valid}, 64'd1);
    step();
    @(negedge clk);
    checkOutput("t4_lb_blocked2", {63'd0, bus_if.transmit_loopback_valid}, 64'd0);
    step();
    bus_if.interface_transmit_ready = 1'b1;
    @(negedge clk);
    checkOutput("t4_lb_blocked3", {63'd0, bus_if.transmit_loopback_valid}, 64'd0);
    step();
    @(negedge clk);
    checkOutput("t4_lb_after_head", {63'd0, bus_if.transmit_loopback_valid}, 64'd1);
    waitEmpty("t4_drain");

    // Pending completion blocks acceptance until acknowledged in the same cycle.
    step();
    bus_if.send_queue_transmit_valid = 1'b1;
    bus_if.send_queue_transmit_data  = '{message: 32'h40, destination: 4'd1, rd: 5'd7, passthrough: '{gl_index: 8'h40}};
    @(negedge clk);
    checkOutput("t5_wb_pending", {63'd0, bus_if.transmit_writeback_arbiter_valid}, 64'd1);
    checkOutput("t5_blocked", {63'd0, bus_if.transmit_send_queue_ready}, 64'd0);
    step();
    bus_if.writeback_arbiter_transmit_acknowledge = 1'b1;
    @(negedge clk);
    checkOutput("t5_ack_ready", {63'd0, bus_if.transmit_send_queue_ready}, 64'd1);
    step();
    bus_if.send_queue_transmit_valid = 1'b0;
    bus_if.writeback_arbiter_transmit_acknowledge = 1'b0;
    @(negedge clk);
    checkOutput("t5_wb_stays", {63'd0, bus_if.transmit_writeback_arbiter_valid}, 64'd1);

    // Flush drops the completion but the buffered messages still go out.
    step();
    step();
    bus_if.interface_transmit_ready = 1'b0;
    bus_if.writeback_arbiter_transmit_acknowledge = 1'b1;
    applyStimulus(4'd1, 32'h50, 5'd5, 8'h50);
    applyStimulus(4'd5, 32'h51, 5'd6, 8'h51);
    bus_if.writeback_arbiter_transmit_acknowledge = 1'b0;
    flush = 1'b1;
    bus_if.send_queue_transmit_valid = 1'b1;
    bus_if.send_queue_transmit_data  = '{message: 32'h52, destination: 4'd1, rd: 5'd8, passthrough: '{gl_index: 8'h52}};
    @(negedge clk);
    checkOutput("t6_flush_ready", {63'd0, bus_if.transmit_send_queue_ready}, 64'd0);
    step();
    flush = 1'b0;
    bus_if.send_queue_transmit_valid = 1'b0;
    @(negedge clk);
    checkOutput("t6_wb_cleared", {63'd0, bus_if.transmit_writeback_arbiter_valid}, 64'd0);
    checkOutput("t6_fifo_kept", {63'd0, bus_if.transmit_interface_valid}, 64'd1);
    step();
    bus_if.interface_transmit_ready = 1'b1;
    waitEmpty("t6_drain");

    // Reset in the middle of a transfer discards the FIFO.
    step();
    bus_if.interface_transmit_ready = 1'b0;
    applyStimulus(4'd1, 32'h60, 5'd10, 8'h60);
    rst_n = 1'b0;
    exp_if_q.delete();
    exp_if_dest_q.delete();
    exp_lb_q.delete();
    exp_wb_q.delete();
    step();
    step();
    rst_n = 1'b1;
    bus_if.interface_transmit_ready = 1'b1;
    @(negedge clk);
    checkOutput("t7_if_valid", {63'd0, bus_if.transmit_interface_valid}, 64'd0);
    checkOutput("t7_lb_valid", {63'd0, bus_if.transmit_loopback_valid}, 64'd0);
    checkOutput("t7_wb_valid", {63'd0, bus_if.transmit_writeback_arbiter_valid}, 64'd0);

    step();
    checkOutput("if_q_drained", 64'(exp_if_q.size()), 64'd0);
    checkOutput("lb_q_drained", 64'(exp_lb_q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
